operator_entry: RTL
===================

Name: operator_entry

Overview:
- Front-panel input block for the I2C prototype board.
- Debounces four pushbuttons and latches slide-switch values into the address register, master data byte and R/W flag, which the Display block shows.
- Issues a one-clock start strobe to the I2C master, then tracks the master's busy handshake until the transfer completes.
- Operands are locked while a transfer is outstanding.

Parameters:
- Fclk, 50000, system clock in kHz.
- F1kHz, 1, debounce sample rate in kHz.
- DEB_N, 8, consecutive differing samples needed to accept a button change (2..15).
- ACK_TO, 255, clocks allowed for busy to rise after st (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- SW  in  8  slide switches, asynchronous
- BTN  in  4  pushbuttons, asynchronous, 1 = pressed; [0] load address, [1] load data, [2] toggle R/W, [3] start
- busy  in  1  I2C master busy, synchronous to clk
- adr_REG  out  8  latched register address
- dat_MASTER  out  8  latched master write data
- R_W  out  1  direction flag, 1 = read
- st  out  1  start strobe, exactly one clk wide
- pend  out  1  start requested, waiting for busy to fall
- err  out  1  sticky ack timeout flag

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0.
  - Tick counter, debounce counters, stable button states, synchronizers and ack counter go to 0.
  - FSM goes to IDLE.
  - Reset asserted mid-transfer abandons it; st is never emitted after reset.
- Synchronizers: SW and BTN each pass through two flops; all logic uses the synced values.
- Sample tick:
  - 16-bit cb_1ms counter; ce = (cb_1ms == Fclk/F1kHz).
  - When ce=1, cb_1ms reloads to 1; otherwise it increments.
  - The first ce occurs Fclk/F1kHz clocks after reset release.
- Debounce, per button, evaluated only when ce=1:
  - If synced value equals the stable state, the 4-bit count clears.
  - Otherwise the count increments; when it reaches DEB_N, the stable state flips and the count clears.
  - A press event is a one-clk pulse on the clk after the stable state goes 0->1.
  - Releases generate no event. Holding a button produces exactly one event.
- Operand actions (press events only, FSM in IDLE):
  - BTN0: adr_REG <= synced SW.
  - BTN1: dat_MASTER <= synced SW.
  - BTN2: R_W <= ~R_W.
  - Several events in the same clk are all applied.
  - Events on BTN0..2 while FSM is not IDLE are discarded, not queued.
- Start FSM, states IDLE, PEND, ISSUE, WAIT_ACK, RUN:
  - IDLE: on BTN3 event, clear err. Go to ISSUE if busy=0, else PEND.
  - PEND: pend=1; when busy=0, go to ISSUE.
  - ISSUE: st=1 for this single clk; ack counter clears; go to WAIT_ACK. Operands latched on the same edge as the BTN3 event are already valid while st=1.
  - WAIT_ACK: if busy=1, go to RUN. Otherwise the counter increments; when it reaches ACK_TO, set err=1 and go to IDLE.
  - RUN: when busy=0, go to IDLE.
  - BTN3 events in any non-IDLE state are ignored.
- Outputs are registered. st and pend are decoded from the state register, with no combinational path from inputs.
- R_W toggle wraps 1->0 naturally. Switch values are 8-bit and latched without modification.

Test Plan (sim with Fclk=4, F1kHz=1, DEB_N=3, ACK_TO=10):
- Reset release, no input:
  - All outputs stay 0.
  - ce pulses every 4 clks; first ce lands 4 clks after reset release.
- SW=8'hA5, BTN0 held clean for 3 ticks:
  - adr_REG=8'hA5 one clk after the stable state flips.
  - Glitch test: BTN0 high for 2 ticks then low for 1 tick. Result: no event, adr_REG unchanged.
- SW=8'h3C with BTN1 press, and BTN2 press in the same clk:
  - dat_MASTER=8'h3C and R_W=1 on the same edge.
  - A second BTN2 press gives R_W=0.
- busy=0, BTN3 press:
  - st high exactly 1 clk.
  - busy raised 2 clks later gives RUN. busy dropped gives IDLE.
  - BTN0 pressed during RUN with SW=8'hFF leaves adr_REG unchanged.
- busy=1 at BTN3 press:
  - pend=1 and st=0 until busy falls; then st pulses once and pend=0.
- BTN3 press, busy never rises:
  - err=1 exactly 10 clks after st; FSM returns to IDLE.
  - Next BTN3 press clears err.
  - rst asserted during WAIT_ACK gives all outputs 0 immediately.

Source files
------------

// File: rtl/operator_entry.sv
// Front-panel input block: button debounce, operand latching and the start/busy
// handshake towards the I2C master.
module operator_entry #(
  parameter int Fclk   = 50000,
  parameter int F1kHz  = 1,
  parameter int DEB_N  = 8,
  parameter int ACK_TO = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] SW,
  input  logic [3:0] BTN,
  input  logic       busy,
  output logic [7:0] adr_REG,
  output logic [7:0] dat_MASTER,
  output logic       R_W,
  output logic       st,
  output logic       pend,
  output logic       err
);

  localparam logic [15:0] TICK_DIV = 16'(Fclk / F1kHz);
  localparam logic [3:0]  DEB_LIM  = 4'(DEB_N);
  localparam logic [7:0]  ACK_LIM  = 8'(ACK_TO);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PEND     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;

  logic [7:0]  r_sw_meta, r_sw_sync;
  logic [3:0]  r_btn_meta, r_btn_sync;
  logic [15:0] r_cb_1ms;
  logic        w_ce;
  logic [3:0]  w_stable;
  logic [3:0]  r_stable_d;
  logic [3:0]  w_press;
  logic [2:0]  r_state;
  logic [7:0]  r_ack_cnt;
  logic [7:0]  r_adr;
  logic [7:0]  r_dat;
  logic        r_rw;
  logic        r_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= BTN;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Sample tick: counts 1..TICK_DIV, first tick TICK_DIV clocks after reset.
  assign w_ce = (r_cb_1ms == TICK_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cb_1ms <= '0;
    end else if (w_ce) begin
      r_cb_1ms <= 16'd1;
    end else begin
      r_cb_1ms <= r_cb_1ms + 16'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic [3:0] r_cnt;
    logic       r_state_bit;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt       <= '0;
        r_state_bit <= 1'b0;
      end else if (w_ce) begin
        if (r_btn_sync[g] == r_state_bit) begin
          r_cnt <= '0;
        end else if ((r_cnt + 4'd1) == DEB_LIM) begin
          r_state_bit <= ~r_state_bit;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end

    assign w_stable[g] = r_state_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_d <= '0;
    end else begin
      r_stable_d <= w_stable;
    end
  end

  // Press event: one clock after the stable state rises; releases are ignored.
  assign w_press = w_stable & ~r_stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ack_cnt <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_rw      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press[0]) r_adr <= r_sw_sync;
          if (w_press[1]) r_dat <= r_sw_sync;
          if (w_press[2]) r_rw  <= ~r_rw;
          if (w_press[3]) begin
            r_err   <= 1'b0;
            r_state <= busy ? S_PEND : S_ISSUE;
          end
        end
        S_PEND: begin
          if (!busy) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_ack_cnt <= '0;
          r_state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (busy) begin
            r_state <= S_RUN;
          end else begin
            // Timeout after ACK_TO waiting clocks with busy still low.
            r_ack_cnt <= r_ack_cnt + 8'd1;
            if ((r_ack_cnt + 8'd1) == ACK_LIM) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (!busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adr_REG    = r_adr;
  assign dat_MASTER = r_dat;
  assign R_W        = r_rw;
  assign err        = r_err;
  assign st         = (r_state == S_ISSUE);
  assign pend       = (r_state == S_PEND);

endmodule
